// File: rtl/bright_pkg.sv
// Shared types and default sizing for the bright MAC row.
package bright_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_ACC_WIDTH = 24;
    localparam int DEF_LANES     = 4;

endpackage

// File: rtl/bright_mac_row_if.sv
// Control, weight-load and streaming handshake bundle for bright_mac_row.
interface bright_mac_row_if
    import bright_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int LANES     = DEF_LANES
);
    logic                       load_start;
    logic                       wt_valid;
    logic [BIT_WIDTH-1:0]       wt_in;
    logic                       run_start;
    logic                       run_stop;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*BIT_WIDTH-1:0] data_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_WIDTH-1:0]       acc_out;
    logic [BIT_WIDTH-1:0]       pix_out;
    logic                       busy;

    modport master (
        output load_start, wt_valid, wt_in, run_start, run_stop, in_valid, data_in, out_ready,
        input  in_ready, out_valid, acc_out, pix_out, busy
    );

    modport slave (
        input  load_start, wt_valid, wt_in, run_start, run_stop, in_valid, data_in, out_ready,
        output in_ready, out_valid, acc_out, pix_out, busy
    );
endinterface

// File: rtl/bright_mac_row_mac_stage.sv
// One lane of the MAC row: weight register plus registered multiply-add with a travelling valid bit.
module mac_stage #(
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 wt_we,
    input  logic [BIT_WIDTH-1:0] wt_in,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic                 valid_in,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 valid_out
);
    localparam int PW = 2 * BIT_WIDTH;

    logic [BIT_WIDTH-1:0] wt_q, wt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 valid_q, valid_d;
    logic [PW-1:0]        prod;

    always_comb begin
        prod    = PW'(data_in) * PW'(wt_q);
        wt_d    = wt_we ? wt_in : wt_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        if (en) begin
            acc_d   = acc_in + ACC_WIDTH'(prod);
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_q    <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            wt_q    <= wt_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
        end
    end

    assign acc_out   = acc_q;
    assign valid_out = valid_q;
endmodule

// File: rtl/bright_mac_row.sv
// Weight-stationary MAC row: skewed lanes feed a chain of mac_stage instances, clamped pixel out.
// state | meaning
// IDLE  | waiting for load_start or run_start
// LOAD  | capturing one weight beat per lane
// RUN   | accepting input vectors
// DRAIN | no new input, flushing in-flight tokens
module bright_mac_row
    import bright_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int SHIFT     = 0
) (
    input  logic            clk,
    input  logic            reset,
    bright_mac_row_if.slave bus
);
    localparam int WCNT_W = $clog2(LANES);
    localparam logic [BIT_WIDTH-1:0] PIX_MAX = '1;

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    state_t                     state_q, state_d;
    logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
    logic                       weights_ok_q, weights_ok_d;
    logic                       busy_q, busy_d;
    logic                       in_v_q, in_v_d;
    logic [LANES*BIT_WIDTH-1:0] in_data_q, in_data_d;
    logic                       out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]       acc_out_q, acc_out_d;
    logic [BIT_WIDTH-1:0]       pix_q, pix_d;
    logic [ACC_WIDTH-1:0]       shifted;

    logic                 adv, in_fire, any_valid;
    logic [LANES-1:0]     wt_we, v_prev, v_chain;
    logic [ACC_WIDTH-1:0] acc_prev  [LANES];
    logic [ACC_WIDTH-1:0] acc_chain [LANES];
    logic [BIT_WIDTH-1:0] lane_data [LANES];

    // Assert asynchronously, release two edges later so every flop leaves reset together.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end
    assign rst_n = rst_sync_q[1];

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state_q == ST_RUN) && !bus.run_stop && adv;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign any_valid    = in_v_q || (|v_chain) || out_valid_q;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        weights_ok_d = weights_ok_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_d      = ST_LOAD;
                    wcnt_d       = '0;
                    weights_ok_d = 1'b0;
                end else if (bus.run_start && weights_ok_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (bus.wt_valid) begin
                    if (wcnt_q == WCNT_W'(LANES - 1)) begin
                        wcnt_d       = '0;
                        weights_ok_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_RUN:   if (bus.run_stop) state_d = ST_DRAIN;
            ST_DRAIN: if (!any_valid)   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_comb begin
        in_v_d      = in_v_q;
        in_data_d   = in_data_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        pix_d       = pix_q;
        shifted     = acc_chain[LANES-1] >> SHIFT;
        if (adv) begin
            in_v_d      = in_fire;
            in_data_d   = bus.data_in;
            out_valid_d = v_chain[LANES-1];
            acc_out_d   = acc_chain[LANES-1];
            pix_d       = (shifted > ACC_WIDTH'(PIX_MAX)) ? PIX_MAX : shifted[BIT_WIDTH-1:0];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign wt_we[k] = (state_q == ST_LOAD) && bus.wt_valid && (wcnt_q == WCNT_W'(k));

        if (k == 0) begin : g_head
            assign lane_data[0] = in_data_q[0 +: BIT_WIDTH];
            assign acc_prev[0]  = '0;
            assign v_prev[0]    = in_v_q;
        end else begin : g_skew
            // Lane k is delayed k beats so it meets the partial sum of lane k-1.
            logic [BIT_WIDTH-1:0] sk_q [k];
            logic [BIT_WIDTH-1:0] sk_d [k];

            always_comb begin
                sk_d[0] = adv ? in_data_q[k*BIT_WIDTH +: BIT_WIDTH] : sk_q[0];
                for (int j = 1; j < k; j++) sk_d[j] = adv ? sk_q[j-1] : sk_q[j];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < k; j++) sk_q[j] <= '0;
                end else begin
                    sk_q <= sk_d;
                end
            end

            assign lane_data[k] = sk_q[k-1];
            assign acc_prev[k]  = acc_chain[k-1];
            assign v_prev[k]    = v_chain[k-1];
        end

        mac_stage #(.BIT_WIDTH(BIT_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (adv),
            .wt_we    (wt_we[k]),
            .wt_in    (bus.wt_in),
            .data_in  (lane_data[k]),
            .acc_in   (acc_prev[k]),
            .valid_in (v_prev[k]),
            .acc_out  (acc_chain[k]),
            .valid_out(v_chain[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            weights_ok_q <= 1'b0;
            busy_q       <= 1'b0;
            in_v_q       <= 1'b0;
            in_data_q    <= '0;
            out_valid_q  <= 1'b0;
            acc_out_q    <= '0;
            pix_q        <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            weights_ok_q <= weights_ok_d;
            busy_q       <= busy_d;
            in_v_q       <= in_v_d;
            in_data_q    <= in_data_d;
            out_valid_q  <= out_valid_d;
            acc_out_q    <= acc_out_d;
            pix_q        <= pix_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.pix_out   = pix_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bright_mac_row.sv
// Randomised bench for bright_mac_row against a dot-product reference model (SHIFT 0 and 2 in parallel).
module tb_bright_mac_row;
    localparam int BW = 8;
    localparam int AW = 24;
    localparam int L  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bright_mac_row_if #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .LANES(L)) bus ();
    bright_mac_row_if #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .LANES(L)) bus2 ();

    bright_mac_row #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .LANES(L), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    bright_mac_row #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .LANES(L), .SHIFT(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    assign bus2.load_start = bus.load_start;
    assign bus2.wt_valid   = bus.wt_valid;
    assign bus2.wt_in      = bus.wt_in;
    assign bus2.run_start  = bus.run_start;
    assign bus2.run_stop   = bus.run_stop;
    assign bus2.in_valid   = bus.in_valid;
    assign bus2.data_in    = bus.data_in;
    assign bus2.out_ready  = bus.out_ready;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: abstract phase, weight table and queue of expected dot products.
    typedef enum {M_IDLE, M_LOAD, M_RUN, M_DRAIN} mstate_t;
    mstate_t       m_state = M_IDLE;
    int unsigned   m_w [L];
    bit            m_ok = 0;
    int            m_cnt = 0;
    logic [AW-1:0] exp_q [$];
    int            n_acc = 0;
    int            n_out = 0;
    bit            hold = 0;
    logic [AW-1:0] hold_acc;
    logic [BW-1:0] hold_pix;

    function automatic logic [AW-1:0] dot(input logic [L*BW-1:0] d);
        longint s = 0;
        for (int k = 0; k < L; k++) s += longint'(d[k*BW +: BW]) * longint'(m_w[k]);
        return AW'(s);
    endfunction

    function automatic logic [BW-1:0] sat(input logic [AW-1:0] a, input int sh);
        longint v;
        v = longint'(a) >> sh;
        return (v > (2**BW - 1)) ? BW'(2**BW - 1) : BW'(v);
    endfunction

    always @(negedge clk) begin
        logic [AW-1:0] e;
        int outstanding;
        if (!reset) begin
            exp_q.delete();
            m_state = M_IDLE;
            m_ok = 0;
            m_cnt = 0;
            for (int k = 0; k < L; k++) m_w[k] = 0;
            hold = 0;
            check_eq("rst_out_valid", bus.out_valid, 0);
            check_eq("rst_busy", bus.busy, 0);
            check_eq("rst_in_ready", bus.in_ready, 0);
        end else begin
            check_eq("busy", bus.busy, m_state != M_IDLE);
            check_eq("in_ready", bus.in_ready,
                     (m_state == M_RUN) && !bus.run_stop && (!bus.out_valid || bus.out_ready));
            if (hold) begin
                check_eq("hold_valid", bus.out_valid, 1);
                check_eq("hold_acc", bus.acc_out, hold_acc);
                check_eq("hold_pix", bus.pix_out, hold_pix);
            end
            hold     = bus.out_valid && !bus.out_ready;
            hold_acc = bus.acc_out;
            hold_pix = bus.pix_out;
            outstanding = exp_q.size();
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", bus.out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("acc_out", bus.acc_out, e);
                    check_eq("pix_out_s0", bus.pix_out, sat(e, 0));
                    check_eq("pix_out_s2", bus2.pix_out, sat(e, 2));
                    check_eq("s2_valid", bus2.out_valid, 1);
                    n_out++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(dot(bus.data_in));
                n_acc++;
            end
            case (m_state)
                M_IDLE: begin
                    if (bus.load_start) begin
                        m_state = M_LOAD; m_ok = 0; m_cnt = 0;
                    end else if (bus.run_start && m_ok) begin
                        m_state = M_RUN;
                    end
                end
                M_LOAD: begin
                    if (bus.wt_valid) begin
                        m_w[m_cnt] = bus.wt_in;
                        m_cnt++;
                        if (m_cnt == L) begin
                            m_cnt = 0; m_ok = 1; m_state = M_IDLE;
                        end
                    end
                end
                M_RUN:   if (bus.run_stop) m_state = M_DRAIN;
                M_DRAIN: if (outstanding == 0) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic ready_pat(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 3) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic feed_beats(input logic [BW-1:0] w [L]);
        for (int k = 0; k < L; k++) begin
            bus.wt_valid = 1'b0;
            bus.wt_in    = BW'($urandom);
            tick($urandom_range(0, 2));
            bus.wt_valid = 1'b1;
            bus.wt_in    = w[k];
            tick(1);
        end
        bus.wt_valid = 1'b0;
    endtask

    task automatic load_weights(input logic [BW-1:0] w [L]);
        bus.load_start = 1'b1;
        tick(1);
        bus.load_start = 1'b0;
        feed_beats(w);
    endtask

    task automatic start_run();
        bus.run_start = 1'b1;
        tick(1);
        bus.run_start = 1'b0;
    endtask

    task automatic stream(input int n, input bit rand_valid, input int rmode);
        int target;
        int c;
        target = n_acc + n;
        c = 0;
        while (n_acc < target && c < 2000) begin
            bus.in_valid  = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.data_in   = $urandom;
            bus.out_ready = ready_pat(rmode, c);
            tick(1);
            c++;
        end
        bus.in_valid = 1'b0;
        check_eq("stream_accepted", n_acc - (target - n), n);
    endtask

    task automatic stop_and_drain();
        int c;
        bus.run_stop = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = $urandom;
        tick(1);
        bus.run_stop = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("stop_busy", bus.busy, 1);
        check_eq("stop_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        c = 0;
        while (bus.busy && c < 100) begin
            tick(1);
            c++;
        end
        check_eq("drain_idle", bus.busy, 0);
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] wd [L];
        logic [BW-1:0] wr [L];
        int base;
        int lat;

        bus.load_start = 1'b0;
        bus.wt_valid   = 1'b0;
        bus.wt_in      = '0;
        bus.run_start  = 1'b0;
        bus.run_stop   = 1'b0;
        bus.in_valid   = 1'b0;
        bus.data_in    = '0;
        bus.out_ready  = 1'b1;
        wd = '{8'd1, 8'd2, 8'd3, 8'd4};

        tick(3);
        check_eq("reset_acc_out", bus.acc_out, 0);
        check_eq("reset_pix_out", bus.pix_out, 0);
        reset = 1'b1;
        tick(4);

        // run_start without weights is ignored
        start_run();
        tick(2);
        check_eq("run_no_weights_busy", bus.busy, 0);
        check_eq("weights_ok_before", dut.weights_ok_q, 0);
        load_weights(wd);
        check_eq("weights_ok_after", dut.weights_ok_q, 1);
        check_eq("load_back_idle", bus.busy, 0);

        // single token latency and values
        start_run();
        bus.out_ready = 1'b1;
        bus.data_in   = {8'd40, 8'd30, 8'd20, 8'd10};
        bus.in_valid  = 1'b1;
        base = n_acc;
        tick(1);
        bus.in_valid = 1'b0;
        check_eq("single_accepted", n_acc - base, 1);
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            tick(1);
            lat++;
        end
        check_eq("latency", lat, L + 1);
        check_eq("acc_300", bus.acc_out, 300);
        check_eq("pix_s0_255", bus.pix_out, 255);
        check_eq("pix_s2_75", bus2.pix_out, 75);
        stop_and_drain();

        // load_start wins over run_start
        bus.load_start = 1'b1;
        bus.run_start  = 1'b1;
        tick(1);
        bus.load_start = 1'b0;
        bus.run_start  = 1'b0;
        check_eq("prio_busy", bus.busy, 1);
        check_eq("prio_not_run", bus.in_ready, 0);
        feed_beats(wd);
        check_eq("prio_weights_ok", dut.weights_ok_q, 1);

        // 8 back-to-back under 1,0,0 out_ready pattern
        start_run();
        base = n_out;
        stream(8, 0, 1);
        stop_and_drain();
        check_eq("bp_delivered", n_out - base, 8);

        // stop with 3 tokens in flight
        start_run();
        base = n_out;
        stream(3, 0, 0);
        stop_and_drain();
        check_eq("drain3_delivered", n_out - base, 3);

        // randomised rounds
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < L; k++) wr[k] = BW'($urandom);
            load_weights(wr);
            start_run();
            bus.load_start = 1'b1;
            tick(1);
            bus.load_start = 1'b0;
            base = n_out;
            stream($urandom_range(5, 20), 1, 2);
            stop_and_drain();
            check_eq("rand_delivered", n_out - base, n_acc - base - (n_acc - n_out));
            check_eq("rand_balance", n_acc, n_out);
        end

        // reset with tokens in flight
        load_weights(wd);
        start_run();
        stream(2, 0, 3);
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            tick(1);
            lat++;
        end
        check_eq("pre_rst_out_valid", bus.out_valid, 1);
        reset = 1'b0;
        #1;
        check_eq("rst_imm_out_valid", bus.out_valid, 0);
        check_eq("rst_imm_busy", bus.busy, 0);
        check_eq("rst_imm_acc", bus.acc_out, 0);
        tick(2);
        reset = 1'b1;
        tick(4);
        check_eq("post_rst_weights_ok", dut.weights_ok_q, 0);
        bus.out_ready = 1'b1;
        base = n_out;
        load_weights(wd);
        start_run();
        tick(10);
        check_eq("no_stale_result", n_out - base, 0);
        stream(4, 1, 2);
        stop_and_drain();
        check_eq("post_rst_delivered", n_out - base, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
